// File: rtl/fpalu_issue_pkg.sv
// Shared definitions for the FPALU issue sequencer: state encoding, opcode width
// and the default watchdog length.
package fpalu_issue_pkg;

  localparam int FP_OP_W             = 5;
  localparam int FP_TIMEOUT_DEFAULT  = 64;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_COMMIT = 2'd3
  } fp_state_e;

endpackage

// File: rtl/fpalu_watchdog.sv
// Clear/enable cycle counter that flags when it reaches TIMEOUT_CYCLES-1.
module fpalu_watchdog #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/fpalu_issue_ctrl.sv
// Multicycle issue/stall/commit sequencer for the FPALU with a watchdog.
// Optional perf counters are enabled with `define FPALU_ISSUE_PERF_EN.
module fpalu_issue_ctrl
  import fpalu_issue_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = FP_TIMEOUT_DEFAULT,
  parameter int CNT_W          = 7
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iFPOp,
  input  logic [FP_OP_W-1:0] iFPControl,
  input  logic               iFPReady,
  input  logic [31:0]        iFPResult,
  input  logic               iClearErr,
  output logic               oFPStart,
  output logic [FP_OP_W-1:0] oFPControl,
  output logic               oStall,
  output logic [31:0]        oResult,
  output logic               oResultValid,
  output logic               oBusy,
  output logic               oTimeout,
  output logic [31:0]        oStallCycles,
  output logic [31:0]        oOpCount
);

  fp_state_e          state_q, state_d;
  logic               start_q, start_d;
  logic [FP_OP_W-1:0] ctrl_q, ctrl_d;
  logic [31:0]        result_q, result_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;
  logic               timeout_set;
  logic               wd_tc;

  fpalu_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_watchdog (
    .clk(iCLK),
    .rst(iRST),
    .clr(state_q == ST_ISSUE),
    .en (state_q == ST_WAIT),
    .tc (wd_tc)
  );

  always_comb begin
    state_d     = state_q;
    start_d     = 1'b0;
    valid_d     = 1'b0;
    ctrl_d      = ctrl_q;
    result_d    = result_q;
    timeout_set = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (iFPOp) begin
          ctrl_d  = iFPControl;
          start_d = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      // Ready seen here may be left over from the previous op, so it is ignored.
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (iFPReady || wd_tc) begin
          timeout_set = !iFPReady;
          result_d    = iFPResult;
          valid_d     = 1'b1;
          state_d     = ST_COMMIT;
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    timeout_d = timeout_set | (timeout_q & ~iClearErr);
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q   <= ST_IDLE;
      start_q   <= 1'b0;
      ctrl_q    <= '0;
      result_q  <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      ctrl_q    <= ctrl_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  // Stall in IDLE is combinational so the PC never moves past the FP instruction.
  assign oStall       = (state_q == ST_IDLE) ? iFPOp : (state_q != ST_COMMIT);
  assign oFPStart     = start_q;
  assign oFPControl   = ctrl_q;
  assign oResult      = result_q;
  assign oResultValid = valid_q;
  assign oBusy        = busy_q;
  assign oTimeout     = timeout_q;

`ifdef FPALU_ISSUE_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] op_count_q, op_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q + {31'd0, oStall};
    op_count_d     = op_count_q + {31'd0, valid_d};
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      stall_cycles_q <= '0;
      op_count_q     <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      op_count_q     <= op_count_d;
    end
  end

  assign oStallCycles = stall_cycles_q;
  assign oOpCount     = op_count_q;
`else
  assign oStallCycles = '0;
  assign oOpCount     = '0;
`endif

endmodule

// File: tb/tb_fpalu_issue_ctrl.sv
// Randomized self-checking bench for fpalu_issue_ctrl against an op-level model.
module tb_fpalu_issue_ctrl;

  localparam int T = 8;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        iFPOp;
  logic [4:0]  iFPControl;
  logic        iFPReady;
  logic [31:0] iFPResult;
  logic        iClearErr;
  logic        oFPStart;
  logic [4:0]  oFPControl;
  logic        oStall;
  logic [31:0] oResult;
  logic        oResultValid;
  logic        oBusy;
  logic        oTimeout;
  logic [31:0] oStallCycles;
  logic [31:0] oOpCount;

  int          compareCount  = 0;
  int          mismatchCount = 0;
  logic        modelTimeout  = 1'b0;
  logic [31:0] modelStalls   = '0;
  logic [31:0] modelOps      = '0;

  fpalu_issue_ctrl #(.TIMEOUT_CYCLES(T), .CNT_W(7)) dut (
    .iCLK(iCLK), .iRST(iRST), .iFPOp(iFPOp), .iFPControl(iFPControl),
    .iFPReady(iFPReady), .iFPResult(iFPResult), .iClearErr(iClearErr),
    .oFPStart(oFPStart), .oFPControl(oFPControl), .oStall(oStall),
    .oResult(oResult), .oResultValid(oResultValid), .oBusy(oBusy),
    .oTimeout(oTimeout), .oStallCycles(oStallCycles), .oOpCount(oOpCount)
  );

  always #5 iCLK = ~iCLK;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compareCount++;
    if (got !== exp) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic checkPerf(input string tag);
`ifdef FPALU_ISSUE_PERF_EN
    checkOutput({tag, "_stallcyc"}, oStallCycles, modelStalls);
    checkOutput({tag, "_opcount"}, oOpCount, modelOps);
`else
    checkOutput({tag, "_stallcyc"}, oStallCycles, 32'd0);
    checkOutput({tag, "_opcount"}, oOpCount, 32'd0);
`endif
  endtask

  task automatic checkIdle(input string tag, input logic expStall);
    checkOutput({tag, "_stall"}, {31'd0, oStall}, {31'd0, expStall});
    checkOutput({tag, "_start"}, {31'd0, oFPStart}, 32'd0);
    checkOutput({tag, "_busy"}, {31'd0, oBusy}, 32'd0);
    checkOutput({tag, "_valid"}, {31'd0, oResultValid}, 32'd0);
    checkOutput({tag, "_timeout"}, {31'd0, oTimeout}, {31'd0, modelTimeout});
  endtask

  // Non-FP cycles: no stall; an optional clear of the sticky flag.
  task automatic applyIdle(input int n, input bit allowClr);
    for (int i = 0; i < n; i++) begin
      @(negedge iCLK);
      iFPOp      = 1'b0;
      iFPControl = 5'($urandom);
      iFPReady   = 1'($urandom);
      iFPResult  = $urandom;
      iClearErr  = allowClr ? 1'($urandom) : 1'b0;
      #1;
      checkIdle("idle", 1'b0);
      @(posedge iCLK);
      if (iClearErr) modelTimeout = 1'b0;
    end
  endtask

  // One FP op. delay = WAIT cycle (1-based) in which ready rises; 0 or >T means never.
  task automatic applyStimulus(input logic [4:0] ctrl, input logic [31:0] res,
                               input int delay, input bit readyInIssue);
    bit  timedOut;
    int  waits;
    timedOut = !(delay >= 1 && delay <= T);
    waits    = timedOut ? T : delay;

    @(negedge iCLK);
    iFPOp = 1'b1; iFPControl = ctrl; iFPReady = 1'($urandom);
    iFPResult = $urandom; iClearErr = 1'b0;
    #1;
    checkIdle("fpidle", 1'b1);
    @(posedge iCLK);
    modelStalls++;

    @(negedge iCLK);
    iFPOp = 1'($urandom); iFPControl = 5'($urandom); iFPReady = readyInIssue;
    #1;
    checkOutput("issue_start", {31'd0, oFPStart}, 32'd1);
    checkOutput("issue_stall", {31'd0, oStall}, 32'd1);
    checkOutput("issue_busy", {31'd0, oBusy}, 32'd1);
    checkOutput("issue_ctrl", {27'd0, oFPControl}, {27'd0, ctrl});
    checkOutput("issue_valid", {31'd0, oResultValid}, 32'd0);
    @(posedge iCLK);
    modelStalls++;

    for (int k = 1; k <= waits; k++) begin
      @(negedge iCLK);
      iFPOp      = 1'($urandom);
      iFPControl = 5'($urandom);
      iFPReady   = (k == delay);
      iFPResult  = (k == waits) ? res : $urandom;
      iClearErr  = ($urandom_range(0, 3) == 0);
      #1;
      checkOutput("wait_stall", {31'd0, oStall}, 32'd1);
      checkOutput("wait_start", {31'd0, oFPStart}, 32'd0);
      checkOutput("wait_valid", {31'd0, oResultValid}, 32'd0);
      checkOutput("wait_ctrl", {27'd0, oFPControl}, {27'd0, ctrl});
      checkOutput("wait_timeout", {31'd0, oTimeout}, {31'd0, modelTimeout});
      @(posedge iCLK);
      modelStalls++;
      if (k == waits && timedOut) modelTimeout = 1'b1;
      else if (iClearErr)         modelTimeout = 1'b0;
    end
    modelOps++;

    @(negedge iCLK);
    iFPOp = 1'($urandom); iFPControl = 5'($urandom); iFPReady = 1'($urandom);
    iClearErr = 1'b0;
    #1;
    checkOutput("commit_valid", {31'd0, oResultValid}, 32'd1);
    checkOutput("commit_stall", {31'd0, oStall}, 32'd0);
    checkOutput("commit_start", {31'd0, oFPStart}, 32'd0);
    checkOutput("commit_result", oResult, res);
    checkOutput("commit_ctrl", {27'd0, oFPControl}, {27'd0, ctrl});
    checkOutput("commit_timeout", {31'd0, oTimeout}, {31'd0, modelTimeout});
    checkPerf("commit");
    @(posedge iCLK);
  endtask

  task automatic applyReset();
    @(negedge iCLK);
    iRST = 1'b1; iFPOp = 1'b0; iClearErr = 1'b0; iFPReady = 1'b0;
    @(posedge iCLK);
    @(negedge iCLK);
    iRST = 1'b0;
    modelTimeout = 1'b0; modelStalls = '0; modelOps = '0;
    #1;
    checkIdle("rst", 1'b0);
    checkOutput("rst_ctrl", {27'd0, oFPControl}, 32'd0);
    checkOutput("rst_result", oResult, 32'd0);
    checkPerf("rst");
    iFPOp = 1'b1;
    #1;
    checkOutput("rst_stall_follow", {31'd0, oStall}, 32'd1);
    iFPOp = 1'b0;
    #1;
    checkOutput("rst_stall_low", {31'd0, oStall}, 32'd0);
    @(posedge iCLK);
  endtask

  initial begin
    iRST = 1'b1; iFPOp = 1'b0; iFPControl = '0; iFPReady = 1'b0;
    iFPResult = '0; iClearErr = 1'b0;
    repeat (2) @(posedge iCLK);
    applyReset();

    applyStimulus(5'h03, 32'h40490FDB, 4, 1'b0);
    applyIdle(1, 1'b0);
    applyStimulus(5'h07, 32'h3F800000, 1, 1'b1);
    applyStimulus(5'h0A, 32'hDEADBEEF, 0, 1'b0);
    applyIdle(2, 1'b0);
    checkOutput("timeout_sticky", {31'd0, oTimeout}, {31'd0, modelTimeout});
    @(negedge iCLK);
    iClearErr = 1'b1;
    @(posedge iCLK);
    modelTimeout = 1'b0;
    applyIdle(1, 1'b0);
    applyStimulus(5'h01, 32'h11111111, 2, 1'b0);
    applyStimulus(5'h02, 32'h22222222, 3, 1'b0);
    applyStimulus(5'h04, 32'h44444444, T, 1'b1);

    // Abort mid-WAIT: start an op by hand and pull reset during WAIT.
    @(negedge iCLK);
    iFPOp = 1'b1; iFPControl = 5'h15; iFPReady = 1'b0;
    repeat (4) @(posedge iCLK);
    @(negedge iCLK);
    iFPOp = 1'b0;
    checkOutput("pre_rst_busy", {31'd0, oBusy}, 32'd1);
    applyReset();
    applyIdle(1, 1'b0);

    for (int n = 0; n < 30; n++) begin
      applyStimulus(5'($urandom), $urandom, $urandom_range(0, T + 2),
                    1'($urandom));
      applyIdle($urandom_range(0, 2), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/fpalu_issue_ctrl.md
Name: fpalu_issue_ctrl

Overview:
Multicycle sequencer for the floating-point ALU in the single-cycle RV32IMF core. On an FR-type instruction it pulses the FPALU start input and holds the PC and register-write enables. It waits for the FPALU ready flag, with a watchdog, then issues a one-cycle commit strobe. This replaces the current "clock sized for worst case" approach, so the core clock no longer depends on FPALU latency.

Parameters:
TIMEOUT_CYCLES, 64, maximum WAIT cycles before a forced commit (must be ≥2)
CNT_W, 7, watchdog counter width (must hold TIMEOUT_CYCLES-1)

Ports:
iCLK  in  1  core clock (same clock as PC and register banks)
iRST  in  1  reset, synchronous, active-high
iFPOp  in  1  current instruction requires the FPALU (from control decode)
iFPControl  in  5  FPALU operation code from control
iFPReady  in  1  FPALU ready flag
iFPResult  in  32  FPALU result
iClearErr  in  1  clears sticky timeout flag
oFPStart  out  1  FPALU start pulse
oFPControl  out  5  latched opcode driven to the FPALU
oStall  out  1  hold PC; suppress RegWrite, FRegWrite and MemWrite
oResult  out  32  latched FPALU result
oResultValid  out  1  one-cycle commit strobe; gates the register write enables
oBusy  out  1  state ≠ IDLE
oTimeout  out  1  sticky watchdog error

Behaviour:
- One clock, iCLK. Reset is synchronous and active-high (iRST sampled on the iCLK rising edge).
- Reset values:
  - state=IDLE, counter=0
  - oFPStart=0, oFPControl=0, oResult=0
  - oResultValid=0, oBusy=0, oTimeout=0
- States: IDLE, ISSUE, WAIT, COMMIT.
- IDLE:
  - oStall = iFPOp, combinational, the same cycle, so the PC does not advance past the FP instruction.
  - If iFPOp: latch iFPControl into oFPControl, then go to ISSUE.
- ISSUE:
  - oFPStart=1 for exactly this cycle; oStall=1; clear the counter.
  - iFPReady is ignored here (stale ready from the previous op), then go to WAIT.
- WAIT:
  - oStall=1; the counter increments each cycle.
  - If iFPReady=1: latch iFPResult into oResult, then go to COMMIT.
  - Else if counter == TIMEOUT_CYCLES-1: set oTimeout, latch iFPResult anyway, then go to COMMIT.
  - If ready and timeout coincide, ready wins and oTimeout is not set.
- COMMIT:
  - oResultValid=1 and oStall=0, so the PC and register write take effect on this edge. Then go to IDLE.
- Back-to-back FP ops: the next instruction is seen in IDLE one cycle after COMMIT. Minimum per-op cost is 3 cycles (ISSUE, WAIT with immediate ready, COMMIT).
- oFPControl holds stable from ISSUE through COMMIT. Changes on iFPControl or iFPOp during ISSUE, WAIT or COMMIT are ignored.
- Non-FP instructions (iFPOp=0 in IDLE) incur no stall or latency.
- oTimeout stays set until iClearErr=1 or reset. iClearErr in the same cycle as a new timeout: set wins.
- Reset mid-operation aborts the op: no commit strobe, all outputs return to their reset values.

Optional Feature:
Macro FPALU_ISSUE_PERF_EN.
- Defined: adds oStallCycles[31:0], counting cycles with oStall=1, and oOpCount[31:0], counting COMMIT entries. Both wrap at 2^32 and are cleared by reset.
- Undefined: both ports still exist and are tied to 0, with no counter flops.

Decomposition:
- Shared package fpalu_issue_pkg: state encoding (2 bits: IDLE=0, ISSUE=1, WAIT=2, COMMIT=3), FPALU opcode width (5), TIMEOUT_CYCLES default.
- One sub-module, fpalu_watchdog: clear/enable counter with terminal-count output. The FSM stays in the top module.

Test Plan:
- Reset then iFPOp=1, iFPControl=5'h03, ready after 4 WAIT cycles, iFPResult=32'h40490FDB:
  - oFPStart high for 1 cycle; oStall high for 6 cycles (IDLE, ISSUE, 4×WAIT).
  - COMMIT: oResultValid=1, oResult=32'h40490FDB, oTimeout=0.
- iFPReady held 1 across ISSUE: ignored in ISSUE; commit occurs after exactly one WAIT cycle.
- iFPReady never asserted, TIMEOUT_CYCLES=8: commit after 8 WAIT cycles; oTimeout=1 and stays 1; iClearErr pulse returns it to 0.
- Two consecutive FP ops with opcodes 5'h01 then 5'h02: two oFPStart pulses; oFPControl=5'h01 then 5'h02; oResultValid asserted twice; no overlap.
- iRST asserted during WAIT: next cycle state=IDLE, oStall follows iFPOp, no oResultValid, counter=0.
- With FPALU_ISSUE_PERF_EN, three ops of 2 WAIT cycles each: oOpCount=3, oStallCycles=12.
